// File: rtl/gol_seed_loader_if.sv
// gol_seed_loader_if: handshake and board bundle shared by host, seed loader and cell array.
interface gol_seed_loader_if #(parameter int N = 64) ();
  logic         start;
  logic [7:0]   genCount;
  logic         seedBit;
  logic         seedValid;
  logic         seedReady;
  logic [N-1:0] boardState;
  logic [N-1:0] initialState;
  logic         initialize;
  logic         busy;
  logic         done;
  logic         extinct;
  logic [7:0]   genElapsed;
  modport master (
    output start, genCount, seedBit, seedValid, boardState,
    input  seedReady, initialState, initialize, busy, done, extinct, genElapsed
  );
  modport slave (
    input  start, genCount, seedBit, seedValid, boardState,
    output seedReady, initialState, initialize, busy, done, extinct, genElapsed
  );
endinterface

// File: rtl/gol_seed_loader.sv
// gol_seed_loader: serially loads a Game of Life seed, runs genCount generations, then freezes the board.
module gol_seed_loader #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  gol_seed_loader_if.slave  bus
);
  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] APPLY = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [N-1:0]  seed_q, seed_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    gen_q, gen_d;
  logic          ext_q, ext_d;

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gen_d   = gen_q;
    ext_d   = ext_q;
    if ((state_q == IDLE || state_q == DONE) && bus.start) begin
      state_d = LOAD;
      seed_d  = '0;
      idx_d   = '0;
      gen_d   = '0;
      ext_d   = 1'b0;
    end else if (state_q == LOAD && bus.seedValid) begin
      seed_d[idx_q] = bus.seedBit;
      idx_d         = idx_q + 1'b1;
      if (idx_q == IW'(N - 1)) begin
        state_d = APPLY;
        cnt_d   = bus.genCount;
      end
    end else if (state_q == APPLY) begin
      state_d = (cnt_q == 8'd0) ? DONE : RUN;
    end else if (state_q == RUN) begin
      // An empty board ends the run without counting this cycle as a generation.
      if (bus.boardState == '0) begin
        state_d = DONE;
        ext_d   = 1'b1;
      end else begin
        cnt_d   = cnt_q - 8'd1;
        gen_d   = gen_q + {7'd0, ~&gen_q};
        state_d = (cnt_q == 8'd1) ? DONE : RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seed_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gen_q   <= '0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gen_q   <= gen_d;
      ext_q   <= ext_d;
    end
  end

  assign bus.seedReady    = state_q == LOAD;
  assign bus.initialize   = state_q != RUN;
  assign bus.initialState = (state_q == DONE) ? bus.boardState : seed_q;
  assign bus.busy         = state_q == LOAD || state_q == APPLY || state_q == RUN;
  assign bus.done         = state_q == DONE;
  assign bus.extinct      = ext_q;
  assign bus.genElapsed   = gen_q;
endmodule
